// File: rtl/pixel_tap_ring_buffer.sv
// Multi-tap pixel delay line for CRT phosphor decay emulation.
// Replicated RAM copies (one per tap) with a hardware clear sweep, fill tracking and per-tap valid flags.
module pixel_tap_ring_buffer #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_TAPS   = 8,
  parameter int TAP_STEP   = 128
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      clear_req,
  input  logic                      shift_en,
  input  logic [WIDTH-1:0]          shiftin,
  output logic                      in_ready,
  output logic [NUM_TAPS*WIDTH-1:0] taps,
  output logic [NUM_TAPS-1:0]       tap_valid,
  output logic [WIDTH-1:0]          shiftout,
  output logic [ADDR_WIDTH:0]       fill_level,
  output logic [ADDR_WIDTH-1:0]     debug_wrptr
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_WIDTH-1:0] ONE_A     = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   ONE_F     = (ADDR_WIDTH+1)'(1);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  if (NUM_TAPS < 2 || NUM_TAPS > 16 || TAP_STEP < 2 ||
      (NUM_TAPS - 1) * TAP_STEP >= DEPTH) begin : g_bad_params
    $error("pixel_tap_ring_buffer: illegal NUM_TAPS/TAP_STEP/ADDR_WIDTH combination");
  end

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
  logic [ADDR_WIDTH-1:0] wrptr_q, wrptr_d;
  logic [ADDR_WIDTH:0]   fill_q, fill_d;
  logic                  in_ready_q;

  logic                  accept;
  logic                  tap_clear;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [WIDTH-1:0]      mem_wdata;

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    wrptr_d    = wrptr_q;
    fill_d     = fill_q;
    accept     = 1'b0;
    tap_clear  = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = wrptr_q;
    mem_wdata  = shiftin;

    if (state_q == ST_CLEAR) begin
      tap_clear = 1'b1;
      mem_we    = 1'b1;
      mem_waddr = clr_addr_q;
      mem_wdata = '0;
      wrptr_d   = '0;
      fill_d    = '0;
      if (clear_req) begin
        clr_addr_d = '0;
      end else begin
        clr_addr_d = clr_addr_q + ONE_A;
        if (clr_addr_q == LAST_ADDR) state_d = ST_RUN;
      end
    end else if (clear_req) begin
      // A clear outranks a shift offered in the same cycle; that sample is dropped.
      state_d    = ST_CLEAR;
      clr_addr_d = '0;
      tap_clear  = 1'b1;
      wrptr_d    = '0;
      fill_d     = '0;
    end else if (shift_en) begin
      accept  = 1'b1;
      mem_we  = 1'b1;
      wrptr_d = wrptr_q + ONE_A;
      if (fill_q != DEPTH_W) fill_d = fill_q + ONE_F;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
      wrptr_q    <= '0;
      fill_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      wrptr_q    <= wrptr_d;
      fill_q     <= fill_d;
      in_ready_q <= (state_d == ST_RUN);
    end
  end

  for (genvar i = 0; i < NUM_TAPS; i++) begin : g_tap
    localparam int                  DELAY   = (i == 0) ? 1 : i * TAP_STEP;
    localparam logic [ADDR_WIDTH:0] DELAY_W = (ADDR_WIDTH+1)'(DELAY);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [WIDTH-1:0]      tap_q;
    logic                  valid_q;

    assign rd_addr = wrptr_q - DELAY_W[ADDR_WIDTH-1:0];

    // NOTE: RAM contents have no reset; the clear sweep zeroes them so the array maps to block RAM.
    always_ff @(posedge clock) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    // Reading mem here returns the pre-write contents, giving read-before-write behaviour.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        tap_q   <= '0;
        valid_q <= 1'b0;
      end else if (tap_clear) begin
        tap_q   <= '0;
        valid_q <= 1'b0;
      end else if (accept) begin
        tap_q   <= mem[rd_addr];
        valid_q <= (fill_q >= DELAY_W);
      end
    end

    assign taps[i*WIDTH +: WIDTH] = tap_q;
    assign tap_valid[i]           = valid_q;
  end

  assign shiftout    = taps[(NUM_TAPS-1)*WIDTH +: WIDTH];
  assign in_ready    = in_ready_q;
  assign fill_level  = fill_q;
  assign debug_wrptr = wrptr_q;

endmodule

// File: tb/tb_pixel_tap_ring_buffer.sv
// Directed bench for pixel_tap_ring_buffer: default instance plus a small-parameter instance.
module tb_pixel_tap_ring_buffer;

  localparam int W = 32, AW = 10, NT = 8, TS = 128, DEPTH = 1024;
  localparam int W2 = 16, AW2 = 8, NT2 = 4, TS2 = 60, DEPTH2 = 256;

  logic              clock;
  logic              reset_n, clear_req, shift_en;
  logic [W-1:0]      shiftin;
  logic              in_ready;
  logic [NT*W-1:0]   taps;
  logic [NT-1:0]     tap_valid;
  logic [W-1:0]      shiftout;
  logic [AW:0]       fill_level;
  logic [AW-1:0]     debug_wrptr;

  logic              reset2_n, clear2, shift2;
  logic [W2-1:0]     shiftin2;
  logic              in_ready2;
  logic [NT2*W2-1:0] taps2;
  logic [NT2-1:0]    tap_valid2;
  logic [W2-1:0]     shiftout2;
  logic [AW2:0]      fill2;
  logic [AW2-1:0]    wrptr2;

  int errors = 0;
  int checks = 0;

  pixel_tap_ring_buffer #(.WIDTH(W), .ADDR_WIDTH(AW), .NUM_TAPS(NT), .TAP_STEP(TS)) dut (
    .clock(clock), .reset_n(reset_n), .clear_req(clear_req), .shift_en(shift_en),
    .shiftin(shiftin), .in_ready(in_ready), .taps(taps), .tap_valid(tap_valid),
    .shiftout(shiftout), .fill_level(fill_level), .debug_wrptr(debug_wrptr)
  );

  pixel_tap_ring_buffer #(.WIDTH(W2), .ADDR_WIDTH(AW2), .NUM_TAPS(NT2), .TAP_STEP(TS2)) dut_small (
    .clock(clock), .reset_n(reset2_n), .clear_req(clear2), .shift_en(shift2),
    .shiftin(shiftin2), .in_ready(in_ready2), .taps(taps2), .tap_valid(tap_valid2),
    .shiftout(shiftout2), .fill_level(fill2), .debug_wrptr(wrptr2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: after n accepted ramp samples (1,2,3,...) a tap with delay d shows n-d, else 0.
  function automatic int exp_val(int n, int d);
    return (n > d) ? n - d : 0;
  endfunction

  function automatic int delay_of(int i, int step);
    return (i == 0) ? 1 : i * step;
  endfunction

  function automatic logic [NT*W-1:0] exp_taps(int n);
    logic [NT*W-1:0] v = '0;
    for (int i = 0; i < NT; i++) v[i*W +: W] = W'(exp_val(n, delay_of(i, TS)));
    return v;
  endfunction

  function automatic logic [NT-1:0] exp_valid(int n);
    logic [NT-1:0] v = '0;
    for (int i = 0; i < NT; i++) v[i] = (n > delay_of(i, TS));
    return v;
  endfunction

  function automatic logic [NT2*W2-1:0] exp_taps2(int n);
    logic [NT2*W2-1:0] v = '0;
    for (int i = 0; i < NT2; i++) v[i*W2 +: W2] = W2'(exp_val(n, delay_of(i, TS2)));
    return v;
  endfunction

  function automatic logic [NT2-1:0] exp_valid2(int n);
    logic [NT2-1:0] v = '0;
    for (int i = 0; i < NT2; i++) v[i] = (n > delay_of(i, TS2));
    return v;
  endfunction

  task automatic do_shift(input int v);
    shift_en = 1'b1;
    shiftin  = W'(v);
    @(posedge clock); #1;
    shift_en = 1'b0;
  endtask

  // Counts clock edges until in_ready rises (bounded); flags any non-zero output seen meanwhile.
  task automatic wait_ready(output int edges, output bit dirty);
    edges = 0;
    dirty = 1'b0;
    while (!in_ready && edges < 5000) begin
      @(posedge clock); #1;
      edges++;
      if (!in_ready && (taps !== '0 || tap_valid !== '0 || fill_level !== '0)) dirty = 1'b1;
    end
  endtask

  task automatic do_clear(output int edges, output bit dirty);
    clear_req = 1'b1;
    @(posedge clock); #1;
    clear_req = 1'b0;
    wait_ready(edges, dirty);
  endtask

  task automatic check_ramp_point(input string tag, input int n);
    checks++;
    if (taps !== exp_taps(n)) begin
      errors++;
      $display("FAIL %s taps n=%0d: got %h expected %h", tag, n, taps, exp_taps(n));
    end
    checks++;
    if (tap_valid !== exp_valid(n)) begin
      errors++;
      $display("FAIL %s tap_valid n=%0d: got %b expected %b", tag, n, tap_valid, exp_valid(n));
    end
    checks++;
    if (shiftout !== W'(exp_val(n, 7 * TS))) begin
      errors++;
      $display("FAIL %s shiftout n=%0d: got %0d expected %0d", tag, n, shiftout, exp_val(n, 7 * TS));
    end
  endtask

  task automatic test_reset();
    int edges;
    bit dirty;
    reset_n = 1'b0; clear_req = 1'b0; shift_en = 1'b1; shiftin = 32'hdead_beef;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (in_ready !== 1'b0)     begin errors++; $display("FAIL reset in_ready: got %b expected 0", in_ready); end
    checks++; if (taps !== '0)           begin errors++; $display("FAIL reset taps: got %h expected 0", taps); end
    checks++; if (tap_valid !== '0)      begin errors++; $display("FAIL reset tap_valid: got %b expected 0", tap_valid); end
    checks++; if (fill_level !== '0)     begin errors++; $display("FAIL reset fill_level: got %0d expected 0", fill_level); end
    checks++; if (debug_wrptr !== '0)    begin errors++; $display("FAIL reset wrptr: got %0d expected 0", debug_wrptr); end
    reset_n = 1'b1;
    wait_ready(edges, dirty);
    shift_en = 1'b0;
    checks++; if (edges != 1024)         begin errors++; $display("FAIL reset sweep length: got %0d expected 1024", edges); end
    checks++; if (dirty)                 begin errors++; $display("FAIL reset outputs during sweep: got nonzero expected zero"); end
    checks++; if (fill_level !== '0)     begin errors++; $display("FAIL reset shift ignored in sweep: fill got %0d expected 0", fill_level); end
    checks++; if (debug_wrptr !== '0)    begin errors++; $display("FAIL reset wrptr after sweep: got %0d expected 0", debug_wrptr); end
  endtask

  task automatic test_ramp();
    for (int n = 1; n <= 600; n++) begin
      do_shift(n);
      check_ramp_point("ramp", n);
      checks++;
      if (fill_level !== (AW+1)'(n) || debug_wrptr !== AW'(n)) begin
        errors++;
        $display("FAIL ramp ptrs n=%0d: got fill=%0d wrptr=%0d expected %0d", n, fill_level, debug_wrptr, n);
      end
      if (n == 384) begin
        checks++;
        if (tap_valid[3] !== 1'b0 || taps[3*W +: W] !== 32'd0) begin
          errors++;
          $display("FAIL ramp tap3 before fill: got valid=%b val=%0d expected 0/0", tap_valid[3], taps[3*W +: W]);
        end
      end
      if (n == 385) begin
        checks++;
        if (tap_valid[3] !== 1'b1 || taps[3*W +: W] !== 32'd1) begin
          errors++;
          $display("FAIL ramp tap3 first valid: got valid=%b val=%0d expected 1/1", tap_valid[3], taps[3*W +: W]);
        end
      end
    end
  endtask

  task automatic test_gaps();
    int edges;
    bit dirty;
    do_clear(edges, dirty);
    checks++; if (edges != 1024) begin errors++; $display("FAIL gaps clear length: got %0d expected 1024", edges); end
    checks++; if (dirty)         begin errors++; $display("FAIL gaps outputs during clear: got nonzero expected zero"); end
    for (int k = 1; k <= 150; k++) begin
      do_shift(k);
      check_ramp_point("gaps_shift", k);
      for (int idle = 0; idle < 3; idle++) begin
        @(posedge clock); #1;
        checks++;
        if (taps !== exp_taps(k) || tap_valid !== exp_valid(k) || debug_wrptr !== AW'(k)) begin
          errors++;
          $display("FAIL gaps idle k=%0d: got wrptr=%0d valid=%b expected wrptr=%0d valid=%b",
                   k, debug_wrptr, tap_valid, k, exp_valid(k));
        end
      end
    end
  endtask

  task automatic test_wrap();
    int edges;
    bit dirty;
    do_clear(edges, dirty);
    checks++; if (edges != 1024) begin errors++; $display("FAIL wrap clear length: got %0d expected 1024", edges); end
    for (int n = 1; n <= 3000; n++) begin
      do_shift(n);
      check_ramp_point("wrap", n);
      checks++;
      if (debug_wrptr !== AW'(n % DEPTH) || fill_level !== (AW+1)'((n < DEPTH) ? n : DEPTH)) begin
        errors++;
        $display("FAIL wrap ptrs n=%0d: got wrptr=%0d fill=%0d expected wrptr=%0d fill=%0d",
                 n, debug_wrptr, fill_level, n % DEPTH, (n < DEPTH) ? n : DEPTH);
      end
    end
  endtask

  task automatic test_clear_collision();
    int edges;
    bit dirty;
    for (int n = 3001; n <= 3500; n++) begin
      do_shift(n);
      checks++;
      if (taps !== exp_taps(n)) begin
        errors++;
        $display("FAIL collision prefill n=%0d: got %h expected %h", n, taps, exp_taps(n));
      end
    end
    shiftin = 32'h0000_beef; shift_en = 1'b1; clear_req = 1'b1;
    @(posedge clock); #1;
    shift_en = 1'b0; clear_req = 1'b0;
    checks++; if (in_ready !== 1'b0 || taps !== '0 || tap_valid !== '0) begin
      errors++; $display("FAIL collision clear edge: got ready=%b valid=%b expected 0/0", in_ready, tap_valid);
    end
    wait_ready(edges, dirty);
    checks++; if (edges != 1024) begin errors++; $display("FAIL collision clear length: got %0d expected 1024", edges); end
    checks++; if (dirty)         begin errors++; $display("FAIL collision outputs during clear: got nonzero expected zero"); end
    checks++; if (debug_wrptr !== '0 || fill_level !== '0) begin
      errors++; $display("FAIL collision dropped shift: got wrptr=%0d fill=%0d expected 0/0", debug_wrptr, fill_level);
    end
    for (int n = 1; n <= 200; n++) begin
      do_shift(n);
      check_ramp_point("refill", n);
    end
  endtask

  task automatic test_async_reset();
    int edges;
    bit dirty;
    @(posedge clock); #3;
    reset_n = 1'b0;
    #1;
    checks++; if (taps !== '0 || tap_valid !== '0) begin
      errors++; $display("FAIL async reset taps: got valid=%b expected 0", tap_valid);
    end
    checks++; if (fill_level !== '0 || debug_wrptr !== '0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL async reset regs: got fill=%0d wrptr=%0d ready=%b expected 0/0/0",
                         fill_level, debug_wrptr, in_ready);
    end
    #2 reset_n = 1'b1;
    repeat (300) @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0 || taps !== '0) begin
      errors++; $display("FAIL midsweep reset: got ready=%b expected 0", in_ready);
    end
    #2 reset_n = 1'b1;
    wait_ready(edges, dirty);
    checks++; if (edges != 1024) begin errors++; $display("FAIL midsweep restart length: got %0d expected 1024", edges); end
    checks++; if (dirty)         begin errors++; $display("FAIL midsweep outputs: got nonzero expected zero"); end
  endtask

  task automatic test_small_params();
    int edges = 0;
    @(posedge clock); #1;
    reset2_n = 1'b1;
    while (!in_ready2 && edges < 2000) begin
      @(posedge clock); #1;
      edges++;
    end
    checks++; if (edges != 256) begin errors++; $display("FAIL small sweep length: got %0d expected 256", edges); end
    for (int n = 1; n <= 250; n++) begin
      shift2 = 1'b1; shiftin2 = W2'(n);
      @(posedge clock); #1;
      shift2 = 1'b0;
      checks++;
      if (taps2 !== exp_taps2(n) || tap_valid2 !== exp_valid2(n)) begin
        errors++;
        $display("FAIL small taps n=%0d: got %h/%b expected %h/%b", n, taps2, tap_valid2, exp_taps2(n), exp_valid2(n));
      end
      checks++;
      if (shiftout2 !== W2'(exp_val(n, 180)) || fill2 !== (AW2+1)'(n) || wrptr2 !== AW2'(n % DEPTH2)) begin
        errors++;
        $display("FAIL small regs n=%0d: got out=%0d fill=%0d wrptr=%0d expected %0d/%0d/%0d",
                 n, shiftout2, fill2, wrptr2, exp_val(n, 180), n, n % DEPTH2);
      end
      if (n == 181) begin
        checks++;
        if (taps2[3*W2 +: W2] !== 16'd1) begin
          errors++; $display("FAIL small tap3 first: got %0d expected 1", taps2[3*W2 +: W2]);
        end
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; clear_req = 1'b0; shift_en = 1'b0; shiftin = '0;
    reset2_n = 1'b0; clear2 = 1'b0; shift2 = 1'b0; shiftin2 = '0;
    test_reset();
    test_ramp();
    test_gaps();
    test_wrap();
    test_clear_collision();
    test_async_reset();
    test_small_params();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pixel_tap_ring_buffer.md
Name: pixel_tap_ring_buffer

Overview:
- Parametrised multi-tap delay line for CRT phosphor decay emulation.
- Sits between the pixel generator and the decay/blend stage: it accepts packed pixel words (Y, X, luma) and presents NUM_TAPS delayed copies at configurable spacing.
- Generalises the fixed 8-tap, 1024-deep buffer with a shift enable, a hardware memory-clear sweep, per-tap valid flags and fill tracking.

Parameters:
- WIDTH, 32, pixel word width (10-bit Y, 10-bit X, 12-bit luma by default).
- ADDR_WIDTH, 10, log2 of depth; DEPTH = 2^ADDR_WIDTH.
- NUM_TAPS, 8, number of tap outputs; range 2..16.
- TAP_STEP, 128, spacing in samples between taps 1..NUM_TAPS-1; requires TAP_STEP >= 2 and (NUM_TAPS-1)*TAP_STEP < DEPTH (elaboration error otherwise).

Ports:
- clock, in, 1, system clock; all logic on rising edge.
- reset_n, in, 1, asynchronous active-low reset.
- clear_req, in, 1, single-cycle pulse that starts a memory-clear sweep.
- shift_en, in, 1, writes shiftin and advances all taps when high and in_ready is high.
- shiftin, in, WIDTH, pixel word to store.
- in_ready, out, 1, high when in RUN state (not clearing).
- taps, out, NUM_TAPS*WIDTH, tap i occupies bits [i*WIDTH +: WIDTH].
- tap_valid, out, NUM_TAPS, bit i high when tap i holds written data (not post-clear zero).
- shiftout, out, WIDTH, equals the oldest tap (tap NUM_TAPS-1).
- fill_level, out, ADDR_WIDTH+1, accepted writes since last clear, saturating at DEPTH.
- debug_wrptr, out, ADDR_WIDTH, current write pointer.

Behaviour:
- Storage: NUM_TAPS replicated single-write/single-read block RAMs, each DEPTH x WIDTH, all written with identical data. Tap i reads its own copy.
- Delays: D_0 = 1; D_i = i*TAP_STEP for i >= 1.
- Async reset (reset_n low): wrptr=0, taps=0, tap_valid=0, fill_level=0, clear address=0, FSM=CLEAR, in_ready=0. Memory contents are not reset; the sweep handles them.
- FSM CLEAR:
  - Each cycle, write 0 to all copies at clr_addr and increment clr_addr.
  - After writing address DEPTH-1, go to RUN next cycle with wrptr=0 and fill_level=0.
  - The sweep lasts exactly DEPTH cycles after reset release.
  - Taps and tap_valid are held at 0 throughout.
  - shift_en is ignored; data is dropped.
  - clear_req during CLEAR restarts the sweep at address 0.
- FSM RUN, accepted shift (shift_en=1), with w = wrptr:
  - Write shiftin at w.
  - Each tap register loads mem_i[(w - D_i) mod DEPTH], read-before-write old data. Tap 0 therefore shows the previously accepted sample.
  - tap_valid[i] loads (fill_level >= D_i), using fill_level before this write.
  - wrptr <= w+1, wrapping modulo DEPTH.
  - fill_level increments, saturating at DEPTH.
  - Output latency: taps update on the clock edge that accepts the shift, so they are visible the cycle after shift_en.
- FSM RUN, shift_en=0: no write; taps, tap_valid, wrptr and fill_level all hold.
- clear_req in RUN: takes priority over shift_en in the same cycle (that shift is dropped). Next state is CLEAR with clr_addr=0; taps and tap_valid clear on the same edge.
- Wrap-around: pointer subtraction is modulo DEPTH. After fill_level saturates, all tap_valid bits stay 1 until the next clear.
- shiftout is identical to the tap NUM_TAPS-1 register; it is not a separate read.
- in_ready is a registered decode of FSM==RUN.

Test Plan:
- Reset release with defaults -> in_ready=0 for exactly 1024 cycles, then 1; taps=0, tap_valid=0, fill_level=0 throughout.
- After clear, shift in ramp values 1,2,3,... continuously -> after the shift carrying value N, tap0=N-1. Tap i (i>=1) equals N-128*i once N > 128*i. tap_valid[3] rises on the shift carrying value 385; before that, tap3=0.
- Ramp with shift_en gaps (1 on, 3 off, repeating) -> taps, tap_valid and debug_wrptr are unchanged on idle cycles; delays are counted in accepted samples, not cycles.
- 3000 continuous shifts -> debug_wrptr wraps 1023->0 without a glitch; tap7 = N-896 across the wrap; fill_level saturates at 1024.
- clear_req and shift_en asserted together after 500 shifts -> shift dropped, in_ready=0 for 1024 cycles; then all taps read 0 with tap_valid=0 until refilled.
- reset_n pulsed low mid-sweep at clr_addr=300 -> outputs go to reset values immediately (asynchronously); the sweep restarts from 0 and takes a full 1024 cycles.
- Non-default parameters (WIDTH=16, ADDR_WIDTH=8, NUM_TAPS=4, TAP_STEP=60) with a ramp -> tap3 = N-180; the clear sweep lasts 256 cycles.
